// File: rtl/pu_dbg_inst_injector_pkg.sv
// Shared instruction-word types and Power-ISA encode helpers used by the
// debug instruction injector.
package pu_dbg_inst_injector_pkg;

    typedef logic [31:0] inst_t;

    typedef enum logic [1:0] {
        DBG_RD_GPR = 2'd0,
        DBG_WR_GPR = 2'd1,
        DBG_RD_MEM = 2'd2,
        DBG_WR_MEM = 2'd3
    } dbg_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_RESP
    } dbg_state_e;

    // ori r0,r0,0 is the canonical no-op
    localparam inst_t INST_NOP = 32'h6000_0000;

    function automatic inst_t enc_addis(input logic [4:0] rt, input logic [4:0] ra,
                                        input logic [15:0] si);
        return {6'd15, rt, ra, si};
    endfunction

    // ori: destination lives in the ra field, source in the rt (rs) field
    function automatic inst_t enc_ori(input logic [4:0] ra_dst, input logic [4:0] rs_src,
                                      input logic [15:0] ui);
        return {6'd24, rs_src, ra_dst, ui};
    endfunction

    function automatic inst_t enc_lwz(input logic [4:0] rt, input logic [4:0] ra,
                                      input logic [15:0] d);
        return {6'd32, rt, ra, d};
    endfunction

    function automatic inst_t enc_stw(input logic [4:0] rs, input logic [4:0] ra,
                                      input logic [15:0] d);
        return {6'd36, rs, ra, d};
    endfunction

    // The SPR number is split into halves which are stored swapped
    function automatic inst_t enc_mtspr(input logic [9:0] spr, input logic [4:0] rs);
        return {6'd31, rs, spr[4:0], spr[9:5], 10'd467, 1'b0};
    endfunction

endpackage

// File: rtl/pu_dbg_inst_injector_encoder.sv
// Combinational map from (command, word index, latched fields) to the
// instruction word at that index plus a flag marking the final word.
module pu_dbg_inst_encoder
    import pu_dbg_inst_injector_pkg::*;
#(
    parameter int DBG_SPR   = 272,
    parameter int SCRATCH_A = 30,
    parameter int SCRATCH_D = 31
) (
    input  dbg_cmd_e    op,
    input  logic [2:0]  idx,
    input  logic [4:0]  gpr,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output inst_t       inst,
    output logic        last
);

    localparam logic [4:0] RA  = 5'(SCRATCH_A);
    localparam logic [4:0] RD  = 5'(SCRATCH_D);
    localparam logic [9:0] SPR = 10'(DBG_SPR);

    always_comb begin
        inst = INST_NOP;
        last = 1'b0;
        case (op)
            DBG_WR_GPR: begin
                last = (idx >= 3'd1);
                inst = (idx == 3'd0) ? enc_addis(gpr, 5'd0, data[31:16])
                                     : enc_ori(gpr, gpr, data[15:0]);
            end
            DBG_RD_GPR: begin
                last = 1'b1;
                inst = enc_mtspr(SPR, gpr);
            end
            DBG_WR_MEM: begin
                last = (idx >= 3'd4);
                case (idx)
                    3'd0:    inst = enc_addis(RA, 5'd0, addr[31:16]);
                    3'd1:    inst = enc_ori(RA, RA, addr[15:0]);
                    3'd2:    inst = enc_addis(RD, 5'd0, data[31:16]);
                    3'd3:    inst = enc_ori(RD, RD, data[15:0]);
                    default: inst = enc_stw(RD, RA, 16'd0);
                endcase
            end
            default: begin
                last = (idx >= 3'd3);
                case (idx)
                    3'd0:    inst = enc_addis(RA, 5'd0, addr[31:16]);
                    3'd1:    inst = enc_ori(RA, RA, addr[15:0]);
                    3'd2:    inst = enc_lwz(RD, RA, 16'd0);
                    default: inst = enc_mtspr(SPR, RD);
                endcase
            end
        endcase
    end

endmodule

// File: rtl/pu_dbg_inst_injector.sv
// Debug instruction injector: turns host debug commands into instruction
// sequences for the fetch mux and returns read-back data from the debug SPR.
module pu_dbg_inst_injector
    import pu_dbg_inst_injector_pkg::*;
#(
    parameter int DBG_SPR        = 272,
    parameter int SCRATCH_A      = 30,
    parameter int SCRATCH_D      = 31,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_gpr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    input  logic        dbg_spr_valid,
    input  logic [31:0] dbg_spr_data
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dbg_state_e        state_q, state_d;
    dbg_cmd_e          op_q, op_d;
    logic [4:0]        gpr_q, gpr_d;
    logic [31:0]       addr_q, addr_d, data_q, data_d;
    logic [2:0]        idx_q, idx_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              inst_valid_q, inst_valid_d;
    inst_t             inst_q, inst_d;

    dbg_cmd_e          enc_op;
    logic [2:0]        enc_idx;
    logic [4:0]        enc_gpr;
    logic [31:0]       enc_addr, enc_data;
    inst_t             enc_inst;
    logic              enc_last;

    // In IDLE the encoder looks at the incoming command (word 0); otherwise
    // it prepares the word after the one currently presented.
    always_comb begin
        if (state_q == ST_IDLE) begin
            enc_op   = dbg_cmd_e'(cmd_op);
            enc_idx  = 3'd0;
            enc_gpr  = cmd_gpr;
            enc_addr = cmd_addr;
            enc_data = cmd_data;
        end else begin
            enc_op   = op_q;
            enc_idx  = idx_q + 3'd1;
            enc_gpr  = gpr_q;
            enc_addr = addr_q;
            enc_data = data_q;
        end
    end

    pu_dbg_inst_encoder #(
        .DBG_SPR   (DBG_SPR),
        .SCRATCH_A (SCRATCH_A),
        .SCRATCH_D (SCRATCH_D)
    ) u_encoder (
        .op   (enc_op),
        .idx  (enc_idx),
        .gpr  (enc_gpr),
        .addr (enc_addr),
        .data (enc_data),
        .inst (enc_inst),
        .last (enc_last)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        gpr_d         = gpr_q;
        addr_d        = addr_q;
        data_d        = data_q;
        idx_d         = idx_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        inst_valid_d  = inst_valid_q;
        inst_d        = inst_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d         = dbg_cmd_e'(cmd_op);
                    gpr_d        = cmd_gpr;
                    addr_d       = cmd_addr;
                    data_d       = cmd_data;
                    idx_d        = 3'd0;
                    inst_d       = enc_inst;
                    last_d       = enc_last;
                    inst_valid_d = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (inst_ready) begin
                    if (last_q) begin
                        inst_valid_d = 1'b0;
                        // Reads (rd_gpr, rd_mem) have op bit 0 clear
                        if (!op_q[0]) begin
                            cnt_d   = '0;
                            state_d = ST_WAIT_RSP;
                        end else begin
                            rsp_data_d    = 32'd0;
                            rsp_timeout_d = 1'b0;
                            state_d       = ST_RESP;
                        end
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        inst_d = enc_inst;
                        last_d = enc_last;
                    end
                end
            end
            ST_WAIT_RSP: begin
                cnt_d = cnt_q + 1'b1;
                if (dbg_spr_valid) begin
                    rsp_data_d    = dbg_spr_data;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d    = 32'd0;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rsp_valid_d = (state_d == ST_RESP);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op_q          <= DBG_RD_GPR;
            gpr_q         <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            idx_q         <= '0;
            last_q        <= 1'b0;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            inst_valid_q  <= 1'b0;
            inst_q        <= INST_NOP;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            gpr_q         <= gpr_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            idx_q         <= idx_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            inst_valid_q  <= inst_valid_d;
            inst_q        <= inst_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign inst_valid  = inst_valid_q;
    assign inst        = inst_q;

endmodule

// File: tb/tb_pu_dbg_inst_injector.sv
// Directed bench for the debug instruction injector: expected instruction
// words and responses are queued per command and matched by a monitor.
module tb_pu_dbg_inst_injector;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_gpr;
    logic [31:0] cmd_addr, cmd_data;
    logic        rsp_valid, rsp_timeout;
    logic [31:0] rsp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst;
    logic        dbg_spr_valid;
    logic [31:0] dbg_spr_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_count = 0;
    logic [31:0] exp_inst_q[$];
    logic [32:0] exp_rsp_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_inst  = 32'd0;

    pu_dbg_inst_injector #(
        .DBG_SPR        (272),
        .SCRATCH_A      (30),
        .SCRATCH_D      (31),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_gpr       (cmd_gpr),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_timeout   (rsp_timeout),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .dbg_spr_valid (dbg_spr_valid),
        .dbg_spr_data  (dbg_spr_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every handshake and response is matched against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall) begin
                check("stall_valid_held", 64'(inst_valid), 64'd1);
                check("stall_inst_held", 64'(inst), 64'(prev_inst));
            end
            prev_stall = inst_valid && !inst_ready;
            prev_inst  = inst;
            if (inst_valid && inst_ready) begin
                hs_count++;
                total++;
                assert (exp_inst_q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_inst observed=0x%08h expected=none", inst);
                end
                if (exp_inst_q.size() != 0) begin
                    automatic logic [31:0] e = exp_inst_q.pop_front();
                    check("inst_word", 64'(inst), 64'(e));
                    $display("inst handshake: word=0x%08h expected=0x%08h", inst, e);
                end
            end
            if (rsp_valid) begin
                total++;
                assert (exp_rsp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_rsp observed=0x%08h expected=none", rsp_data);
                end
                if (exp_rsp_q.size() != 0) begin
                    automatic logic [32:0] r = exp_rsp_q.pop_front();
                    check("rsp_timeout", 64'(rsp_timeout), 64'(r[32]));
                    check("rsp_data", 64'(rsp_data), 64'(r[31:0]));
                    $display("response: data=0x%08h timeout=%0d", rsp_data, rsp_timeout);
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_cmd(input logic [1:0] op, input logic [4:0] gpr,
                            input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_before_cmd", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_gpr   = gpr;
        cmd_addr  = addr;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((exp_inst_q.size() != 0 || exp_rsp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check({tag, "_inst_q_empty"}, 64'(exp_inst_q.size()), 64'd0);
        check({tag, "_rsp_q_empty"}, 64'(exp_rsp_q.size()), 64'd0);
        check({tag, "_cmd_ready_idle"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        int base;
        int n;
        int t_hs;
        int t_rsp;
        reset         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_op        = 2'd0;
        cmd_gpr       = 5'd0;
        cmd_addr      = 32'd0;
        cmd_data      = 32'd0;
        inst_ready    = 1'b1;
        dbg_spr_valid = 1'b0;
        dbg_spr_data  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst_nop", 64'(inst), 64'h6000_0000);
        reset = 1'b0;

        // wr_gpr r5 <- 0x12345678
        exp_inst_q.push_back(32'h3CA0_1234);
        exp_inst_q.push_back(32'h60A5_5678);
        exp_rsp_q.push_back({1'b0, 32'd0});
        send_cmd(2'd1, 5'd5, 32'd0, 32'h1234_5678);
        wait_idle("wr_gpr");

        // wr_mem [0x100] <- 0xDEADBEEF
        exp_inst_q.push_back(32'h3FC0_0000);
        exp_inst_q.push_back(32'h63DE_0100);
        exp_inst_q.push_back(32'h3FE0_DEAD);
        exp_inst_q.push_back(32'h63FF_BEEF);
        exp_inst_q.push_back(32'h93FE_0000);
        exp_rsp_q.push_back({1'b0, 32'd0});
        send_cmd(2'd3, 5'd7, 32'h0000_0100, 32'hDEAD_BEEF);
        wait_idle("wr_mem");

        // Stray SPR write while idle must not produce a response
        @(negedge clk);
        dbg_spr_valid = 1'b1;
        dbg_spr_data  = 32'h1111_1111;
        @(negedge clk);
        dbg_spr_valid = 1'b0;

        // rd_gpr r3, data returned two cycles after the mtspr handshake
        exp_inst_q.push_back(32'h7C70_43A6);
        exp_rsp_q.push_back({1'b0, 32'hCAFE_F00D});
        send_cmd(2'd0, 5'd3, 32'd0, 32'd0);
        n = 0;
        while (!(inst_valid && inst_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rd_gpr_handshake_seen", 64'(inst_valid && inst_ready), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        dbg_spr_valid = 1'b1;
        dbg_spr_data  = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        dbg_spr_valid = 1'b0;
        check("rd_gpr_rsp_latency", 64'(rsp_valid), 64'd1);
        check("rd_gpr_rsp_data_direct", 64'(rsp_data), 64'hCAFE_F00D);
        wait_idle("rd_gpr");

        // wr_gpr r1 with three stall cycles before each handshake
        base = hs_count;
        inst_ready = 1'b0;
        exp_inst_q.push_back(32'h3C20_ABCD);
        exp_inst_q.push_back(32'h6021_0001);
        exp_rsp_q.push_back({1'b0, 32'd0});
        send_cmd(2'd1, 5'd1, 32'd0, 32'hABCD_0001);
        for (int w = 0; w < 2; w++) begin
            repeat (3) @(posedge clk);
            #1 inst_ready = 1'b1;
            @(posedge clk);
            #1 inst_ready = 1'b0;
        end
        inst_ready = 1'b1;
        wait_idle("stall");
        check("stall_handshake_count", 64'(hs_count - base), 64'd2);

        // rd_mem [0x200] with no SPR write -> timeout after 16 wait cycles
        exp_inst_q.push_back(32'h3FC0_0000);
        exp_inst_q.push_back(32'h63DE_0200);
        exp_inst_q.push_back(32'h83FE_0000);
        exp_inst_q.push_back(32'h7FF0_43A6);
        exp_rsp_q.push_back({1'b1, 32'd0});
        send_cmd(2'd2, 5'd9, 32'h0000_0200, 32'd0);
        n = 0;
        t_hs = -1000;
        while (n < 50) begin
            if (inst_valid && inst_ready && inst == 32'h7FF0_43A6) begin
                t_hs = cyc;
                break;
            end
            @(negedge clk);
            n++;
        end
        n = 0;
        t_rsp = -1;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (rsp_valid) begin
                t_rsp = cyc;
                break;
            end
        end
        check("timeout_rsp_cycle", 64'(t_rsp - t_hs), 64'd17);
        check("timeout_flag_direct", 64'(rsp_timeout), 64'd1);
        @(negedge clk);
        check("timeout_cmd_ready_next", 64'(cmd_ready), 64'd1);
        wait_idle("timeout");

        // Reset after the second wr_mem handshake abandons the sequence
        exp_inst_q.push_back(32'h3FC0_0000);
        exp_inst_q.push_back(32'h63DE_0100);
        send_cmd(2'd3, 5'd0, 32'h0000_0100, 32'hDEAD_BEEF);
        n = 0;
        base = 0;
        while (base < 2 && n < 50) begin
            @(negedge clk);
            n++;
            if (inst_valid && inst_ready) base++;
        end
        check("reset_two_handshakes", 64'(base), 64'd2);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        inst_ready = 1'b0;
        @(posedge clk);
        #1;
        check("reset_inst_valid_drop", 64'(inst_valid), 64'd0);
        check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset_inst_q_consumed", 64'(exp_inst_q.size()), 64'd0);
        reset      = 1'b0;
        inst_ready = 1'b1;
        exp_inst_q.delete();
        exp_rsp_q.delete();

        // Fresh wr_gpr r5 restarts at word 0
        exp_inst_q.push_back(32'h3CA0_1234);
        exp_inst_q.push_back(32'h60A5_ABCD);
        exp_rsp_q.push_back({1'b0, 32'd0});
        send_cmd(2'd1, 5'd5, 32'd0, 32'h1234_ABCD);
        wait_idle("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
